// File: rtl/sd_bidir_pio_if.sv
// Register-bus bundle for sd_bidir_pio: slave-select, active-low write,
// 3-bit register address and 32-bit read/write data.
interface sd_bidir_pio_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/sd_bidir_pio.sv
// Bidirectional PIO: per-pin output/direction registers, 2-flop input sync,
// edge capture with write-1-to-clear, and a masked level interrupt.
module sd_bidir_pio #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_OUT = '0,
    parameter logic [WIDTH-1:0] RESET_DIR = '0,
    parameter int               EDGE_TYPE = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    sd_bidir_pio_if.slave    bus,
    inout  wire  [WIDTH-1:0] bidir_port,
    output logic             irq
);
    logic [WIDTH-1:0] r_data_out, r_dir, r_irqmask, r_edgecap;
    logic [WIDTH-1:0] r_sync1, r_sync_in, r_prev_in;
    logic [31:0]      r_readdata;

    logic             w_wr;
    logic [WIDTH-1:0] w_wdata, w_edge, w_clr;
    logic [31:0]      w_rdata;
    logic             w_unused;

    assign w_wr     = bus.chipselect && !bus.write_n;
    assign w_wdata  = bus.writedata[WIDTH-1:0];
    assign w_unused = ^{1'b0, bus.writedata};

    genvar g;
    generate
        for (g = 0; g < WIDTH; g++) begin : g_pin
            assign bidir_port[g] = r_dir[g] ? r_data_out[g] : 1'bz;
        end
    endgenerate

    always_comb begin
        w_edge = '0;
        case (EDGE_TYPE)
            0:       w_edge = r_sync_in & ~r_prev_in;
            1:       w_edge = ~r_sync_in & r_prev_in;
            default: w_edge = r_sync_in ^ r_prev_in;
        endcase
    end

    assign w_clr = (w_wr && bus.address == 3'd3) ? w_wdata : '0;

    always_comb begin
        w_rdata = '0;
        case (bus.address)
            3'd0:    w_rdata[WIDTH-1:0] = r_sync_in;
            3'd1:    w_rdata[WIDTH-1:0] = r_dir;
            3'd2:    w_rdata[WIDTH-1:0] = r_irqmask;
            3'd3:    w_rdata[WIDTH-1:0] = r_edgecap;
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data_out <= RESET_OUT;
            r_dir      <= RESET_DIR;
            r_irqmask  <= '0;
            r_edgecap  <= '0;
            r_sync1    <= '0;
            r_sync_in  <= '0;
            r_prev_in  <= '0;
            r_readdata <= '0;
        end else begin
            r_sync1    <= bidir_port;
            r_sync_in  <= r_sync1;
            r_prev_in  <= r_sync_in;
            r_readdata <= w_rdata;
            // A fresh edge overrides a simultaneous clear of the same bit
            r_edgecap  <= (r_edgecap & ~w_clr) | w_edge;
            if (w_wr) begin
                case (bus.address)
                    3'd0:    r_data_out <= w_wdata;
                    3'd1:    r_dir      <= w_wdata;
                    3'd2:    r_irqmask  <= w_wdata;
                    3'd4:    r_data_out <= r_data_out | w_wdata;
                    3'd5:    r_data_out <= r_data_out & ~w_wdata;
                    default: ;
                endcase
            end
        end
    end

    assign bus.readdata = r_readdata;
    assign irq          = |(r_edgecap & r_irqmask);
endmodule

// File: doc/sd_bidir_pio.md
SD_BIDIR_PIO -- requirements
Module: sd_bidir_pio

Interface
REQ-001 Parameter WIDTH, default 4: number of bidirectional pins, legal range 1..32.
REQ-002 Parameter RESET_OUT, default 0: reset value of the output data register, WIDTH bits.
REQ-003 Parameter RESET_DIR, default 0: reset value of the direction register, WIDTH bits, where 1 means drive.
REQ-004 Parameter EDGE_TYPE, default 0: edge that sets capture bits, where 0 = rising, 1 = falling, 2 = any.
REQ-005 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-006 reset_n  input  1  reset, asynchronous, active-low.
REQ-007 address  input  3  register select.
REQ-008 chipselect  input  1  slave select.
REQ-009 write_n  input  1  active-low write strobe; qualified by chipselect.
REQ-010 writedata  input  32  write data; bits [31:WIDTH] ignored.
REQ-011 readdata  output  32  registered read data.
REQ-012 bidir_port  inout  WIDTH  external pins.
REQ-013 irq  output  1  active-high level interrupt.

Function
REQ-014 Write strobe SHALL be chipselect && !write_n; writes SHALL take effect on the next clk edge.
REQ-015 Register map SHALL be:
- 0 DATA: read returns sync_in; write loads data_out.
- 1 DIR: read/write.
- 2 IRQMASK: read/write.
- 3 EDGECAP: read returns capture bits; write-1-to-clear.
- 4 OUTSET: write ORs data_out with writedata; reads 0.
- 5 OUTCLR: write clears data_out where writedata is 1; reads 0.
- 6, 7: reserved; writes ignored, reads 0.
REQ-016 Each bidir_port[i] SHALL be driven with data_out[i] when dir[i]=1 and SHALL be high-Z otherwise.
REQ-017 Pin inputs SHALL pass through a 2-flop synchronizer to form sync_in, plus a third flop prev_in used for edge detection; pin-to-sync_in latency SHALL be 2 clk.
REQ-018 An edge on bit i SHALL be detected as follows:
- rising: sync_in & ~prev_in
- falling: ~sync_in & prev_in
- any: sync_in ^ prev_in
A detected edge SHALL set edgecap[i] on the same clk.
REQ-019 Edges SHALL be captured regardless of dir, so a driven pin also captures its own transitions.
REQ-020 If an edge is detected on the same clk as a clear write to that bit, the edge SHALL win and edgecap[i] SHALL stay 1.
REQ-021 irq SHALL equal OR-reduction of (edgecap & irqmask), decoded from registers, with no extra delay.
REQ-022 readdata SHALL be registered every clk, independent of chipselect (1-cycle read latency); bits [31:WIDTH] SHALL read 0.
REQ-023 A DIR change SHALL take effect on the pin in the cycle after the write; data_out SHALL be retained while dir=0.

Reset
REQ-024 While reset_n=0, registers SHALL hold:
- data_out = RESET_OUT
- dir = RESET_DIR
- irqmask = 0
- edgecap = 0
- synchronizer, prev_in and readdata = 0
REQ-025 Consequently irq SHALL be 0 during reset.
REQ-026 The first edge evaluation after reset SHALL compare against prev_in=0; for EDGE_TYPE 0 or 2, a pin held high through reset SHALL capture one edge.

Verification
REQ-027 WIDTH=4, external pins driven 4'b1010, DIR=0 -> read address 0 returns 0x0000000A when the read is issued 3 or more clk after the pins settle.
REQ-028 Write DIR=0xF, then DATA=0x5, then OUTSET=0x2, then OUTCLR=0x1 -> bidir_port sequence 0101 -> 0111 -> 0110; read DATA returns 0x6.
REQ-029 EDGE_TYPE=0, IRQMASK=0x1, pin0 rises -> edgecap=0x1 and irq=1 three clk after the pin edge; write EDGECAP=0x1 -> irq=0 next clk.
REQ-030 Pin0 edge detected on the same clk as an EDGECAP=0x1 clear write -> edgecap[0] stays 1 and irq stays 1.
REQ-031 Assert reset_n mid-operation with DIR=0xF and edgecap=0x3 -> pins return to the RESET_DIR/RESET_OUT state, irq=0 and readdata=0 immediately, with no clk required.
REQ-032 Write address 6 with 0xFFFFFFFF -> no register changes; reads of addresses 4, 5, 6 and 7 return 0.
